pipelined_ripple_adder: RTL and testbench

PIPELINED_RIPPLE_ADDER -- requirements
Module: pipelined_ripple_adder

---
 rtl/pipelined_ripple_adder.sv | 102 ++++++++++
 tb/tb_pipelined_ripple_adder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pipelined_ripple_adder.sv
// pipelined_ripple_adder: N_STAGES-deep segmented ripple adder/subtractor with skewed operand pipeline.
// Define PIPELINED_RIPPLE_ADDER_OVERFLOW_EN to generate the registered signed-overflow flag.
module pipelined_ripple_adder #(
  parameter int WIDTH    = 8,
  parameter int N_STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             x_vld,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic             res_vld,
  output logic [WIDTH:0]   z,
  output logic             ovf
);
  localparam int SLICE = (N_STAGES > 0) ? WIDTH / N_STAGES : 1;
  localparam int L     = N_STAGES - 1;
  if (N_STAGES < 1 || N_STAGES > WIDTH || (WIDTH % N_STAGES) != 0) begin : g_bad_params
    $fatal(1, "pipelined_ripple_adder: illegal WIDTH/N_STAGES combination");
  end
  // Stage s consumes operand bits [LO+SLICE-1:LO]; only bits above that are carried forward.
  for (genvar s = 0; s < N_STAGES; s++) begin : g_st
    localparam int LO = s * SLICE;
    logic [WIDTH-1:LO]     w_xi;
    logic [WIDTH-1:LO]     w_yi;
    logic [LO+SLICE-1:0]   w_so;
    logic [SLICE-1:0]      w_ss;
    logic [SLICE:0]        w_c;
    logic                  w_vi;
    logic                  w_ci;
    if (s == 0) begin : g_in
      assign w_xi = x;
      assign w_yi = y ^ {WIDTH{sub}};
      assign w_ci = sub;
      assign w_vi = x_vld;
      assign w_so = w_ss;
    end else begin : g_in
      assign w_xi = g_st[s-1].g_pipe.r_x;
      assign w_yi = g_st[s-1].g_pipe.r_y;
      assign w_ci = g_st[s-1].g_pipe.r_c;
      assign w_vi = g_st[s-1].g_pipe.r_v;
      assign w_so = {w_ss, g_st[s-1].g_pipe.r_s};
    end
    always_comb begin
      w_c    = '0;
      w_ss   = '0;
      w_c[0] = w_ci;
      for (int b = 0; b < SLICE; b++) begin
        w_ss[b]   = w_xi[LO+b] ^ w_yi[LO+b] ^ w_c[b];
        w_c[b+1]  = (w_xi[LO+b] & w_yi[LO+b]) | (w_c[b] & (w_xi[LO+b] ^ w_yi[LO+b]));
      end
    end
    if (s < L) begin : g_pipe
      logic [WIDTH-1:LO+SLICE] r_x;
      logic [WIDTH-1:LO+SLICE] r_y;
      logic [LO+SLICE-1:0]     r_s;
      logic                    r_v;
      logic                    r_c;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_v <= 1'b0;
          r_c <= 1'b0;
          r_x <= '0;
          r_y <= '0;
          r_s <= '0;
        end else if (clk_en) begin
          r_v <= w_vi;
          r_c <= w_c[SLICE];
          r_x <= w_xi[WIDTH-1:LO+SLICE];
          r_y <= w_yi[WIDTH-1:LO+SLICE];
          r_s <= w_so;
        end
      end
    end
  end
  logic           r_res_vld;
  logic [WIDTH:0] r_z;
  // Result register only loads on a valid result so bubbles leave z untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_vld <= 1'b0;
      r_z       <= '0;
    end else if (clk_en) begin
      r_res_vld <= g_st[L].w_vi;
      if (g_st[L].w_vi) r_z <= {g_st[L].w_c[SLICE], g_st[L].w_so};
    end
  end
  assign res_vld = r_res_vld;
  assign z       = r_z;
`ifdef PIPELINED_RIPPLE_ADDER_OVERFLOW_EN
  logic r_ovf;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ovf <= 1'b0;
    else if (clk_en && g_st[L].w_vi) r_ovf <= g_st[L].w_c[SLICE] ^ g_st[L].w_c[SLICE-1];
  end
  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// tb_pipelined_ripple_adder: directed checks of the 8-bit, 4-stage pipelined ripple adder.
module tb_pipelined_ripple_adder;
`ifdef PIPELINED_RIPPLE_ADDER_OVERFLOW_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clk_en = 1'b1;
  logic       x_vld = 1'b0;
  logic [7:0] x = '0;
  logic [7:0] y = '0;
  logic       sub = 1'b0;
  logic       res_vld;
  logic [8:0] z;
  logic       ovf;
  int         n_vec = 0;
  int         n_err = 0;

  pipelined_ripple_adder #(.WIDTH(8), .N_STAGES(4)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .x_vld(x_vld), .x(x), .y(y),
    .sub(sub), .res_vld(res_vld), .z(z), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic s);
    @(negedge clk);
    x = a;
    y = b;
    sub = s;
    x_vld = 1'b1;
  endtask

  // Issues one op and samples res_vld around the expected 4-edge latency.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                        output logic early, output logic hit, output logic after,
                        output logic [8:0] zo, output logic oo);
    drive(a, b, s);
    @(negedge clk);
    x_vld = 1'b0;
    early = res_vld;
    repeat (2) begin
      @(negedge clk);
      early = early | res_vld;
    end
    @(negedge clk);
    hit = res_vld;
    zo  = z;
    oo  = ovf;
    @(negedge clk);
    after = res_vld;
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #1;
    n_vec++; if (res_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld: got %b want 0", res_vld); end
    n_vec++; if (z !== 9'h000) begin n_err++; $display("FAIL reset_z: got %h want 000", z); end
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_vec++; if (res_vld !== 1'b0) begin n_err++; $display("FAIL reset_hold_vld: got %b want 0", res_vld); end
  endtask

  task automatic test_add;
    logic e, h, a;
    logic [8:0] zo;
    logic oo;
    run_op(8'hFF, 8'h01, 1'b0, e, h, a, zo, oo);
    n_vec++; if (e !== 1'b0) begin n_err++; $display("FAIL add_ff_early: got %b want 0", e); end
    n_vec++; if (h !== 1'b1) begin n_err++; $display("FAIL add_ff_vld: got %b want 1", h); end
    n_vec++; if (zo !== 9'h100) begin n_err++; $display("FAIL add_ff_z: got %h want 100", zo); end
    n_vec++; if (oo !== 1'b0) begin n_err++; $display("FAIL add_ff_ovf: got %b want 0", oo); end
    n_vec++; if (a !== 1'b0) begin n_err++; $display("FAIL add_ff_vld_drop: got %b want 0", a); end
    run_op(8'h7F, 8'h01, 1'b0, e, h, a, zo, oo);
    n_vec++; if (h !== 1'b1) begin n_err++; $display("FAIL add_7f_vld: got %b want 1", h); end
    n_vec++; if (zo !== 9'h080) begin n_err++; $display("FAIL add_7f_z: got %h want 080", zo); end
    n_vec++; if (oo !== OVF_ON) begin n_err++; $display("FAIL add_7f_ovf: got %b want %b", oo, OVF_ON); end
  endtask

  task automatic test_sub;
    logic e, h, a;
    logic [8:0] zo;
    logic oo;
    run_op(8'h05, 8'h07, 1'b1, e, h, a, zo, oo);
    n_vec++; if (h !== 1'b1) begin n_err++; $display("FAIL sub_borrow_vld: got %b want 1", h); end
    n_vec++; if (zo !== 9'h0FE) begin n_err++; $display("FAIL sub_borrow_z: got %h want 0fe", zo); end
    n_vec++; if (oo !== 1'b0) begin n_err++; $display("FAIL sub_borrow_ovf: got %b want 0", oo); end
    run_op(8'h80, 8'h01, 1'b1, e, h, a, zo, oo);
    n_vec++; if (zo !== 9'h17F) begin n_err++; $display("FAIL sub_80_z: got %h want 17f", zo); end
    n_vec++; if (oo !== OVF_ON) begin n_err++; $display("FAIL sub_80_ovf: got %b want %b", oo, OVF_ON); end
    n_vec++; if (a !== 1'b0) begin n_err++; $display("FAIL sub_80_vld_drop: got %b want 0", a); end
  endtask

  task automatic test_back_to_back;
    logic [8:0] exp_z [4];
    exp_z[0] = 9'd3;
    exp_z[1] = 9'd7;
    exp_z[2] = 9'd30;
    exp_z[3] = 9'h12C;
    drive(8'd1, 8'd2, 1'b0);
    drive(8'd3, 8'd4, 1'b0);
    drive(8'd10, 8'd20, 1'b0);
    drive(8'd200, 8'd100, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      x_vld = 1'b0;
      n_vec++; if (res_vld !== 1'b1) begin n_err++; $display("FAIL b2b_vld[%0d]: got %b want 1", i, res_vld); end
      n_vec++; if (z !== exp_z[i]) begin n_err++; $display("FAIL b2b_z[%0d]: got %h want %h", i, z, exp_z[i]); end
    end
    @(negedge clk);
    n_vec++; if (res_vld !== 1'b0) begin n_err++; $display("FAIL b2b_vld_end: got %b want 0", res_vld); end
  endtask

  task automatic test_stall;
    drive(8'h12, 8'h34, 1'b0);
    @(negedge clk);
    x_vld = 1'b0;
    @(negedge clk);
    clk_en = 1'b0;
    n_vec++; if (res_vld !== 1'b0) begin n_err++; $display("FAIL stall_pre_vld: got %b want 0", res_vld); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++; if (res_vld !== 1'b0) begin n_err++; $display("FAIL stall_vld[%0d]: got %b want 0", i, res_vld); end
      n_vec++; if (z !== 9'h12C) begin n_err++; $display("FAIL stall_z_hold[%0d]: got %h want 12c", i, z); end
    end
    clk_en = 1'b1;
    @(negedge clk);
    n_vec++; if (res_vld !== 1'b0) begin n_err++; $display("FAIL stall_edge6_vld: got %b want 0", res_vld); end
    @(negedge clk);
    clk_en = 1'b0;
    n_vec++; if (res_vld !== 1'b1) begin n_err++; $display("FAIL stall_edge7_vld: got %b want 1", res_vld); end
    n_vec++; if (z !== 9'h046) begin n_err++; $display("FAIL stall_edge7_z: got %h want 046", z); end
    @(negedge clk);
    clk_en = 1'b1;
    n_vec++; if (res_vld !== 1'b1) begin n_err++; $display("FAIL stall_vld_hold: got %b want 1", res_vld); end
    n_vec++; if (z !== 9'h046) begin n_err++; $display("FAIL stall_z_hold_out: got %h want 046", z); end
    @(negedge clk);
    n_vec++; if (res_vld !== 1'b0) begin n_err++; $display("FAIL stall_vld_drop: got %b want 0", res_vld); end
  endtask

  task automatic test_reset_midflight;
    drive(8'h11, 8'h22, 1'b0);
    drive(8'h33, 8'h44, 1'b0);
    @(negedge clk);
    x_vld = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_vec++; if (res_vld !== 1'b0) begin n_err++; $display("FAIL midrst_vld: got %b want 0", res_vld); end
    n_vec++; if (z !== 9'h000) begin n_err++; $display("FAIL midrst_z: got %h want 000", z); end
    @(negedge clk);
    rst = 1'b0;
    drive(8'h55, 8'h0A, 1'b0);
    n_vec++; if (res_vld !== 1'b0) begin n_err++; $display("FAIL midrst_stale0: got %b want 0", res_vld); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      x_vld = 1'b0;
      n_vec++; if (res_vld !== 1'b0) begin n_err++; $display("FAIL midrst_stale[%0d]: got %b want 0", i + 1, res_vld); end
      n_vec++; if (z !== 9'h000) begin n_err++; $display("FAIL midrst_z_stale[%0d]: got %h want 000", i + 1, z); end
    end
    @(negedge clk);
    n_vec++; if (res_vld !== 1'b1) begin n_err++; $display("FAIL midrst_new_vld: got %b want 1", res_vld); end
    n_vec++; if (z !== 9'h05F) begin n_err++; $display("FAIL midrst_new_z: got %h want 05f", z); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
